// File: rtl/sdt_unit_pkg.sv
// Shared types and constants for the single-data-transfer execute unit.
// Optional register-offset shifter is enabled by defining SDT_REG_SHIFT_EN.
package sdt_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_MEM     = 3'd2,
        ST_WB_BASE = 3'd3,
        ST_WB_RD   = 3'd4,
        ST_DONE    = 3'd5
    } sdt_state_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } sdt_shift_e;

    localparam logic [3:0] BE_WORD  = 4'b1111;
    localparam logic [3:0] BE_BYTE0 = 4'b0001;

    typedef struct packed {
        logic        immediate;
        logic        pre;
        logic        up;
        logic        word;
        logic        write;
        logic        load;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [11:0] offset;
    } sdt_op_t;

    function automatic logic [7:0] byte_lane(logic [31:0] w, logic [1:0] lane);
        logic [7:0] b;
        unique case (lane)
            2'd0: b = w[7:0];
            2'd1: b = w[15:8];
            2'd2: b = w[23:16];
            2'd3: b = w[31:24];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    function automatic logic [3:0] byte_be(logic [1:0] lane);
        return BE_BYTE0 << lane;
    endfunction

endpackage

// File: rtl/sdt_offset_shifter.sv
// Combinational barrel shifter for register offsets (LSL/LSR/ASR/ROR by imm5).
// Only present when SDT_REG_SHIFT_EN is defined.
`ifdef SDT_REG_SHIFT_EN
module sdt_offset_shifter
    import sdt_unit_pkg::*;
(
    input  logic [31:0] rm_i,
    input  logic [1:0]  shift_type_i,
    input  logic [4:0]  shift_amt_i,
    output logic [31:0] offset_o
);

    logic        amt_zero;
    logic [5:0]  ror_back;

    assign amt_zero = (shift_amt_i == 5'd0);
    assign ror_back = 6'd32 - {1'b0, shift_amt_i};

    // Amount 0 encodes LSR#32 / ASR#32; ROR#0 is plain Rm (no RRX).
    always_comb begin
        offset_o = rm_i;
        unique case (sdt_shift_e'(shift_type_i))
            SH_LSL: offset_o = rm_i << shift_amt_i;
            SH_LSR: offset_o = amt_zero ? 32'd0 : rm_i >> shift_amt_i;
            SH_ASR: offset_o = amt_zero ? {32{rm_i[31]}}
                                        : 32'($signed(rm_i) >>> shift_amt_i);
            SH_ROR: offset_o = amt_zero ? rm_i
                                        : (rm_i >> shift_amt_i) | (rm_i << ror_back);
            default: offset_o = rm_i;
        endcase
    end

endmodule
`endif

// File: rtl/sdt_unit.sv
// LDR/STR/LDRB/STRB execute unit: address generation, one memory access, write-back.
// Define SDT_REG_SHIFT_EN to shift register offsets; otherwise Rm is used unshifted.
module sdt_unit
    import sdt_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        sdt_en,
    input  logic        sdt_immediate,
    input  logic        sdt_pre,
    input  logic        sdt_up,
    input  logic        sdt_word,
    input  logic        sdt_write,
    input  logic        sdt_load,
    input  logic [3:0]  sdt_rn,
    input  logic [3:0]  sdt_rd,
    input  logic [11:0] sdt_offset,
    output logic [3:0]  reg_ra_addr,
    input  logic [31:0] reg_ra_data,
    output logic [3:0]  reg_rb_addr,
    input  logic [31:0] reg_rb_data,
    output logic [3:0]  reg_rc_addr,
    input  logic [31:0] reg_rc_data,
    output logic        reg_we,
    output logic [3:0]  reg_waddr,
    output logic [31:0] reg_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        sdt_busy,
    output logic        sdt_done,
    output logic        sdt_err
);

    sdt_state_e  state_q, state_d;
    sdt_op_t     op_q, op_d;
    logic [31:0] ea_q, ea_d;
    logic [31:0] sum_q, sum_d;
    logic [31:0] stdata_q, stdata_d;
    logic [31:0] ldata_q, ldata_d;
    logic        err_q, err_d;

    logic [31:0] off_c;
    logic [31:0] sum_c;

`ifdef SDT_REG_SHIFT_EN
    logic [31:0] shifted_rm;

    sdt_offset_shifter u_shift (
        .rm_i         (reg_rc_data),
        .shift_type_i (op_q.offset[6:5]),
        .shift_amt_i  (op_q.offset[11:7]),
        .offset_o     (shifted_rm)
    );

    assign off_c = op_q.immediate ? shifted_rm : {20'd0, op_q.offset};
`else
    assign off_c = op_q.immediate ? reg_rc_data : {20'd0, op_q.offset};
`endif

    assign sum_c = op_q.up ? (reg_ra_data + off_c) : (reg_ra_data - off_c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            ea_q     <= '0;
            sum_q    <= '0;
            stdata_q <= '0;
            ldata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            ea_q     <= ea_d;
            sum_q    <= sum_d;
            stdata_q <= stdata_d;
            ldata_q  <= ldata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        ea_d        = ea_q;
        sum_d       = sum_q;
        stdata_d    = stdata_q;
        ldata_d     = ldata_q;
        err_d       = sdt_en && (state_q != ST_IDLE);

        reg_ra_addr = 4'd0;
        reg_rb_addr = 4'd0;
        reg_rc_addr = 4'd0;
        reg_we      = 1'b0;
        reg_waddr   = 4'd0;
        reg_wdata   = 32'd0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = 32'd0;
        mem_be      = 4'd0;
        mem_wdata   = 32'd0;
        sdt_busy    = (state_q != ST_IDLE);
        sdt_done    = 1'b0;
        sdt_err     = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (sdt_en) begin
                    op_d = '{immediate: sdt_immediate, pre: sdt_pre,
                             up: sdt_up, word: sdt_word,
                             write: sdt_write, load: sdt_load,
                             rn: sdt_rn, rd: sdt_rd, offset: sdt_offset};
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                reg_ra_addr = op_q.rn;
                reg_rb_addr = op_q.rd;
                reg_rc_addr = op_q.offset[3:0];
                sum_d       = sum_c;
                ea_d        = op_q.pre ? sum_c : reg_ra_data;
                stdata_d    = op_q.word ? reg_rb_data : {4{reg_rb_data[7:0]}};
                state_d     = ST_MEM;
            end
            ST_MEM: begin
                mem_req   = 1'b1;
                mem_we    = !op_q.load;
                mem_addr  = op_q.word ? {ea_q[31:2], 2'b00} : ea_q;
                mem_be    = op_q.word ? BE_WORD : byte_be(ea_q[1:0]);
                mem_wdata = stdata_q;
                if (mem_ack) begin
                    ldata_d = op_q.word ? mem_rdata
                                        : {24'd0, byte_lane(mem_rdata, ea_q[1:0])};
                    if (!op_q.pre || op_q.write) begin
                        state_d = ST_WB_BASE;
                    end else if (op_q.load) begin
                        state_d = ST_WB_RD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_WB_BASE: begin
                reg_we    = 1'b1;
                reg_waddr = op_q.rn;
                reg_wdata = sum_q;
                state_d   = op_q.load ? ST_WB_RD : ST_DONE;
            end
            ST_WB_RD: begin
                reg_we    = 1'b1;
                reg_waddr = op_q.rd;
                reg_wdata = ldata_q;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                sdt_done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
